// File: rtl/serial_add_pkg.sv
// serial_add_pkg: shared state encoding and nibble width for the serial adder.
package serial_add_pkg;
    localparam int NIBBLE_W = 4;
    typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;
endpackage

// File: rtl/nibble_adder.sv
// nibble_adder: 4-bit ripple adder; exposes carry into the MSB when SERIAL_ADD_OVF_EN is defined.
module nibble_adder
    import serial_add_pkg::*;
(
    input  logic [NIBBLE_W-1:0] a,
    input  logic [NIBBLE_W-1:0] b,
    input  logic                cin,
`ifdef SERIAL_ADD_OVF_EN
    output logic                c3,
`endif
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);
    logic w_c3;
    assign {w_c3, s[2:0]} = {1'b0, a[2:0]} + {1'b0, b[2:0]} + {3'b0, cin};
    assign {cout, s[3]}   = {1'b0, a[3]} + {1'b0, b[3]} + {1'b0, w_c3};
`ifdef SERIAL_ADD_OVF_EN
    assign c3 = w_c3;
`endif
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: nibble-serial adder reusing one 4-bit adder over NIBBLES cycles.
// Optional signed-overflow output ovf when SERIAL_ADD_OVF_EN is defined.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                      clock,
    input  logic                      resetn,
    input  logic                      start,
    input  logic [NIBBLE_W*NIBBLES-1:0] a,
    input  logic [NIBBLE_W*NIBBLES-1:0] b,
    input  logic                      cin,
    output logic                      busy,
    output logic                      done,
    output logic [NIBBLE_W*NIBBLES-1:0] sum,
    output logic                      cout
`ifdef SERIAL_ADD_OVF_EN
    ,output logic                     ovf
`endif
);
    localparam int W  = NIBBLE_W * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST = IW'(NIBBLES - 1);

    state_t            r_state;
    logic [W-1:0]      r_a, r_b, r_sum;
    logic [IW-1:0]     r_idx;
    logic              r_carry, r_cout, r_busy, r_done;
    logic [NIBBLE_W-1:0] w_s;
    logic              w_co;
`ifdef SERIAL_ADD_OVF_EN
    logic              w_c3, r_ovf;
    assign ovf = r_ovf;
`endif

    nibble_adder u_add (
        .a    (r_a[r_idx*NIBBLE_W +: NIBBLE_W]),
        .b    (r_b[r_idx*NIBBLE_W +: NIBBLE_W]),
        .cin  (r_carry),
`ifdef SERIAL_ADD_OVF_EN
        .c3   (w_c3),
`endif
        .s    (w_s),
        .cout (w_co)
    );

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state <= IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef SERIAL_ADD_OVF_EN
            r_ovf   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ADD: begin
                    r_sum[r_idx*NIBBLE_W +: NIBBLE_W] <= w_s;
                    r_carry <= w_co;
                    if (r_idx == LAST) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_cout  <= w_co;
`ifdef SERIAL_ADD_OVF_EN
                        r_ovf   <= w_c3 ^ w_co;
`endif
                    end else begin
                        r_idx <= r_idx + 1'b1;
                    end
                end
                IDLE, DONE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_state <= ADD;
                        r_busy  <= 1'b1;
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= cin;
                        r_idx   <= '0;
                    end else begin
                        r_state <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against integer arithmetic.
// Also checks ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add_ctrl;
    logic        clock = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic [15:0] a = '0, b = '0;
    logic        cin = 1'b0;
    logic        busy, done, cout;
    logic [15:0] sum;
`ifdef SERIAL_ADD_OVF_EN
    logic        ovf;
`endif
    int n_cmp = 0, n_err = 0;

    serial_add_ctrl #(.NIBBLES(4)) dut (
        .clock  (clock),
        .resetn (resetn),
        .start  (start),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .cout   (cout)
`ifdef SERIAL_ADD_OVF_EN
        ,.ovf   (ovf)
`endif
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        @(negedge clock);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy, output bit seen);
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (busy && done) chk("busy_and_done", 1, 0);
            if (done) begin
                seen = 1'b1;
                return;
            end
            if (busy) nbusy++;
            @(negedge clock);
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        logic [16:0] full;
        full = 17'(ta) + 17'(tb_v) + 17'(tc);
        chk({tag, "_sum"}, 32'(sum), 32'(full[15:0]));
        chk({tag, "_cout"}, 32'(cout), 32'(full[16]));
`ifdef SERIAL_ADD_OVF_EN
        chk({tag, "_ovf"}, 32'(ovf), 32'((ta[15] == tb_v[15]) && (full[15] != ta[15])));
`endif
    endtask

    task automatic full_op(input string tag, input logic [15:0] ta, input logic [15:0] tb_v, input logic tc);
        int nb;
        bit seen;
        start_op(ta, tb_v, tc);
        wait_done(nb, seen);
        chk({tag, "_done_seen"}, 32'(seen), 1);
        chk({tag, "_busy_cycles"}, 32'(nb), 4);
        check_result(tag, ta, tb_v, tc);
        @(negedge clock);
        chk({tag, "_done_pulse"}, 32'(done), 0);
    endtask

    initial begin
        int nb, cnt, ndone;
        bit seen;
        logic [15:0] ra, rb, hold;
        logic rc;

        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_sum", 32'(sum), 0);
        chk("rst_cout", 32'(cout), 0);
        @(negedge clock);
        resetn = 1'b1;

        full_op("basic", 16'h1234, 16'h4321, 1'b0);
        full_op("ripple", 16'hFFFF, 16'h0001, 1'b0);
        full_op("cin", 16'h0FFF, 16'hF000, 1'b1);
`ifdef SERIAL_ADD_OVF_EN
        full_op("ovf", 16'h7FFF, 16'h0001, 1'b0);
        chk("ovf_sum", 32'(sum), 32'h8000);
`endif

        hold = sum;
        repeat (3) @(negedge clock);
        chk("idle_hold", 32'(sum), 32'(hold));

        for (int i = 0; i < 8; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            rc = 1'($urandom);
            full_op("rand", ra, rb, rc);
        end

        start_op(16'h1111, 16'h1111, 1'b0);
        @(negedge clock);
        a = 16'h0001; b = 16'h0001; start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_done(nb, seen);
        chk("ign_done_seen", 32'(seen), 1);
        chk("ign_sum", 32'(sum), 32'h2222);
        ndone = 0;
        repeat (8) begin
            @(negedge clock);
            if (done) ndone++;
        end
        chk("ign_single_done", 32'(ndone), 0);

        start_op(16'hABCD, 16'h1357, 1'b1);
        @(negedge clock);
        #2 resetn = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(done), 0);
        chk("mid_rst_sum", 32'(sum), 0);
        chk("mid_rst_cout", 32'(cout), 0);
        @(negedge clock);
        resetn = 1'b1;
        ndone = 0;
        repeat (8) begin
            @(negedge clock);
            if (done || busy) ndone++;
        end
        chk("mid_rst_no_done", 32'(ndone), 0);
        full_op("after_rst", 16'h2468, 16'h1357, 1'b0);

        start_op(16'h00FF, 16'h0F01, 1'b0);
        wait_done(nb, seen);
        chk("b2b_first_seen", 32'(seen), 1);
        check_result("b2b_first", 16'h00FF, 16'h0F01, 1'b0);
        a = 16'h8000; b = 16'h8001; cin = 1'b1; start = 1'b1;
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            cnt++;
            if (done) break;
        end
        start = 1'b0;
        chk("b2b_gap", 32'(cnt), 5);
        check_result("b2b_second", 16'h8000, 16'h8001, 1'b1);

        repeat (2) @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
